// File: rtl/thumb_pkg.sv
// thumb_pkg: shared micro-op codes, constants and the decoded beat record
package thumb_pkg;
  typedef enum logic [3:0] {
    UOP_NOP = 4'd0,
    UOP_ADD = 4'd1,
    UOP_SUB = 4'd2,
    UOP_AND = 4'd3,
    UOP_EOR = 4'd4,
    UOP_CMP = 4'd5,
    UOP_LSL = 4'd6,
    UOP_ORR = 4'd7,
    UOP_MOV = 4'd8,
    UOP_STR = 4'd9,
    UOP_LDR = 4'd10
  } uop_e;
  localparam logic [3:0] COND_ALWAYS = 4'b1110;
  localparam logic [3:0] COND_NONE = 4'b1111;
  localparam logic [3:0] LR_SEL = 4'd14;
  typedef struct packed {
    uop_e        uop;
    logic        num_to_rhs;
    logic [21:0] num;
    logic [3:0]  sel_p0;
    logic [3:0]  sel_p1;
    logic [3:0]  sel_in;
    logic [3:0]  branch_cond;
    logic        is_bl;
    logic        undef;
  } decoded_t;
  localparam decoded_t BEAT_NONE = '{
    uop: UOP_NOP, num_to_rhs: 1'b0, num: '0, sel_p0: '0, sel_p1: '0,
    sel_in: '0, branch_cond: COND_NONE, is_bl: 1'b0, undef: 1'b0
  };
endpackage

// File: rtl/thumb_decode_comb.sv
// thumb_decode_comb: single-halfword thumb-16 decode into a decoded_t beat
module thumb_decode_comb
  import thumb_pkg::*;
(
  input  logic [15:0] instr,
  output decoded_t    dec
);
  always_comb begin
    dec = BEAT_NONE;
    casez (instr)
      16'b0001_10??_????_????: begin
        dec.uop = instr[9] ? UOP_SUB : UOP_ADD;
        dec.sel_p0 = {1'b0, instr[8:6]};
        dec.sel_p1 = {1'b0, instr[5:3]};
        dec.sel_in = {1'b0, instr[2:0]};
      end
      16'b0001_11??_????_????: begin
        dec.uop = instr[9] ? UOP_SUB : UOP_ADD;
        dec.num_to_rhs = 1'b1;
        dec.num = 22'(instr[8:6]);
        dec.sel_p1 = {1'b0, instr[5:3]};
        dec.sel_in = {1'b0, instr[2:0]};
      end
      16'b0000_0???_????_????: begin
        dec.uop = UOP_LSL;
        dec.num_to_rhs = 1'b1;
        dec.num = 22'(instr[10:6]);
        dec.sel_p1 = {1'b0, instr[5:3]};
        dec.sel_in = {1'b0, instr[2:0]};
      end
      16'b001?_????_????_????: begin
        dec.uop = instr[12] ? (instr[11] ? UOP_SUB : UOP_ADD) : (instr[11] ? UOP_CMP : UOP_MOV);
        dec.num_to_rhs = 1'b1;
        dec.num = 22'(instr[7:0]);
        dec.sel_p1 = instr[12:11] == 2'b00 ? 4'd0 : {1'b0, instr[10:8]};
        dec.sel_in = instr[12:11] == 2'b01 ? 4'd0 : {1'b0, instr[10:8]};
      end
      16'b0100_0000_00??_????, 16'b0100_0000_01??_????, 16'b0100_0011_00??_????: begin
        dec.uop = instr[8] ? UOP_ORR : (instr[6] ? UOP_EOR : UOP_AND);
        dec.sel_p0 = {1'b0, instr[2:0]};
        dec.sel_p1 = {1'b0, instr[5:3]};
        dec.sel_in = {1'b0, instr[2:0]};
      end
      16'b0110_????_????_????: begin
        dec.uop = instr[11] ? UOP_LDR : UOP_STR;
        dec.num_to_rhs = 1'b1;
        dec.num = 22'(instr[10:6]);
        dec.sel_p1 = {1'b0, instr[5:3]};
        dec.sel_p0 = instr[11] ? 4'd0 : {1'b0, instr[2:0]};
        dec.sel_in = instr[11] ? {1'b0, instr[2:0]} : 4'd0;
      end
      16'b1101_111?_????_????: dec.undef = 1'b1;
      16'b1101_????_????_????: begin
        dec.branch_cond = instr[11:8];
        dec.num = 22'($signed(instr[7:0]));
      end
      16'b1110_0???_????_????: begin
        dec.branch_cond = COND_ALWAYS;
        dec.num = 22'($signed(instr[10:0]));
      end
      default: dec.undef = 1'b1;
    endcase
  end
endmodule

// File: rtl/thumb_decode_pipe.sv
// thumb_decode_pipe: registered thumb-16 decode stage with bl pairing, handshakes and flush
module thumb_decode_pipe
  import thumb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SEL_W = 4,
  parameter int UOP_W = 5,
  parameter int EN_BL = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [UOP_W-1:0]  uop,
  output logic              num_to_rhs,
  output logic [DATA_W-1:0] num,
  output logic [SEL_W-1:0]  sel_p0,
  output logic [SEL_W-1:0]  sel_p1,
  output logic [SEL_W-1:0]  sel_in,
  output logic [3:0]        branch_cond,
  output logic              is_bl,
  output logic              undef
);
  typedef enum logic {IDLE, PREFIX} state_e;
  localparam logic BL_ON = EN_BL != 0;
  state_e state;
  logic [10:0] hi;
  decoded_t beat, dec, nxt;
  logic xfer, is_pre, is_suf;
  thumb_decode_comb u_dec (.instr(in_instr), .dec(dec));
  assign in_ready = !out_valid || out_ready;
  assign xfer = in_valid && in_ready && !flush;
  assign is_pre = in_instr[15:11] == 5'b11110;
  assign is_suf = in_instr[15:11] == 5'b11111;
  always_comb begin
    nxt = BEAT_NONE;
    nxt.undef = 1'b1;
    if (state == IDLE) nxt = dec;
    else if (is_suf) begin
      nxt.undef = 1'b0;
      nxt.is_bl = 1'b1;
      nxt.branch_cond = COND_ALWAYS;
      nxt.sel_in = LR_SEL;
      nxt.num = {hi, in_instr[10:0]};
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hi <= '0;
      out_valid <= 1'b0;
      beat <= BEAT_NONE;
    end else if (flush) begin
      state <= IDLE;
      out_valid <= 1'b0;
    end else if (xfer) begin
      if (BL_ON && state == IDLE && is_pre) begin
        state <= PREFIX;
        hi <= in_instr[10:0];
        out_valid <= 1'b0;
      end else begin
        state <= IDLE;
        out_valid <= 1'b1;
        beat <= nxt;
      end
    end else if (out_ready) out_valid <= 1'b0;
  end
  assign uop = UOP_W'(beat.uop);
  assign num_to_rhs = beat.num_to_rhs;
  assign num = DATA_W'($signed(beat.num));
  assign sel_p0 = SEL_W'(beat.sel_p0);
  assign sel_p1 = SEL_W'(beat.sel_p1);
  assign sel_in = SEL_W'(beat.sel_in);
  assign branch_cond = beat.branch_cond;
  assign is_bl = beat.is_bl;
  assign undef = beat.undef;
endmodule

// File: tb/tb_thumb_decode_pipe.sv
// tb_thumb_decode_pipe: directed and randomized checks of the decode stage against a behavioural model
module tb_thumb_decode_pipe;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic [15:0] in_instr = '0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, num_to_rhs, is_bl, undef;
  logic [4:0] uop;
  logic [31:0] num;
  logic [3:0] sel_p0, sel_p1, sel_in, branch_cond;
  logic [57:0] obs;
  int checks = 0;
  int failures = 0;
  bit m_valid, m_pre;
  int m_hi;
  logic [4:0] e_uop;
  logic e_rhs, e_bl, e_ud;
  logic [31:0] e_num;
  logic [3:0] e_p0, e_p1, e_in, e_cond;
  thumb_decode_pipe dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready), .uop(uop),
    .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in),
    .branch_cond(branch_cond), .is_bl(is_bl), .undef(undef)
  );
  always #5 clk = ~clk;
  assign obs = {out_valid, in_ready, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, branch_cond, is_bl, undef};
  function automatic logic [57:0] exp_vec();
    return {m_valid, !m_valid || out_ready, e_uop, e_rhs, e_num, e_p0, e_p1, e_in, e_cond, e_bl, e_ud};
  endfunction
  task automatic model_clear();
    e_uop = 0; e_rhs = 0; e_num = 0; e_p0 = 0; e_p1 = 0; e_in = 0;
    e_cond = 4'hF; e_bl = 0; e_ud = 0;
  endtask
  task automatic model_reset();
    m_valid = 0; m_pre = 0; m_hi = 0;
    model_clear();
  endtask
  task automatic model_decode(input int h);
    int top5, rd, rs, rm, imm5, imm8, r8, v;
    top5 = h >> 11; rd = h & 7; rs = (h >> 3) & 7; rm = (h >> 6) & 7;
    imm5 = (h >> 6) & 31; imm8 = h & 255; r8 = (h >> 8) & 7;
    model_clear();
    if ((h >> 10) == 6) begin
      e_uop = ((h >> 9) & 1) != 0 ? 5'd2 : 5'd1;
      e_p0 = 4'(rm); e_p1 = 4'(rs); e_in = 4'(rd);
    end else if ((h >> 10) == 7) begin
      e_uop = ((h >> 9) & 1) != 0 ? 5'd2 : 5'd1;
      e_rhs = 1; e_num = 32'(rm); e_p1 = 4'(rs); e_in = 4'(rd);
    end else if (top5 == 0) begin
      e_uop = 5'd6; e_rhs = 1; e_num = 32'(imm5); e_p1 = 4'(rs); e_in = 4'(rd);
    end else if (top5 >= 4 && top5 <= 7) begin
      e_rhs = 1; e_num = 32'(imm8);
      if (top5 == 4) begin e_uop = 5'd8; e_in = 4'(r8); end
      else if (top5 == 5) begin e_uop = 5'd5; e_p1 = 4'(r8); end
      else begin e_uop = top5 == 6 ? 5'd1 : 5'd2; e_p1 = 4'(r8); e_in = 4'(r8); end
    end else if ((h >> 6) == 'h100 || (h >> 6) == 'h101 || (h >> 6) == 'h10C) begin
      e_uop = (h >> 6) == 'h100 ? 5'd3 : (h >> 6) == 'h101 ? 5'd4 : 5'd7;
      e_p0 = 4'(rd); e_in = 4'(rd); e_p1 = 4'(rs);
    end else if (top5 == 12 || top5 == 13) begin
      e_rhs = 1; e_num = 32'(imm5); e_p1 = 4'(rs);
      if (top5 == 12) begin e_uop = 5'd9; e_p0 = 4'(rd); end
      else begin e_uop = 5'd10; e_in = 4'(rd); end
    end else if ((h >> 12) == 13 && ((h >> 8) & 15) < 14) begin
      e_cond = 4'((h >> 8) & 15);
      v = imm8 >= 128 ? imm8 - 256 : imm8;
      e_num = 32'(v);
    end else if (top5 == 28) begin
      e_cond = 4'hE;
      v = h & 2047;
      e_num = 32'(v >= 1024 ? v - 2048 : v);
    end else e_ud = 1;
  endtask
  task automatic model_step();
    int h, top5, v;
    bit x;
    h = int'(in_instr);
    top5 = h >> 11;
    x = in_valid && (!m_valid || out_ready) && !flush;
    if (flush) begin
      m_valid = 0; m_pre = 0;
    end else if (x) begin
      if (!m_pre && top5 == 30) begin
        m_pre = 1; m_hi = h & 2047; m_valid = 0;
      end else if (m_pre) begin
        m_pre = 0; m_valid = 1;
        model_clear();
        if (top5 == 31) begin
          v = m_hi * 2048 + (h & 2047);
          if (v >= (1 << 21)) v = v - (1 << 22);
          e_num = 32'(v); e_cond = 4'hE; e_bl = 1; e_in = 4'd14;
        end else e_ud = 1;
      end else begin
        model_decode(h);
        m_valid = 1;
      end
    end else if (out_ready) m_valid = 0;
  endtask
  task automatic cyc(input logic v, input logic [15:0] h, input logic r, input logic f);
    in_valid = v; in_instr = h; out_ready = r; flush = f;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step();
    #1;
  endtask
  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_valid, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, branch_cond, is_bl, undef} !==
        {1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset got=%h want valid=0 fields=0 cond=f", obs);
    end
    @(negedge clk) reset = 1'b1;
  endtask
  task automatic test_add_reg();
    cyc(1'b1, 16'h1888, 1'b1, 1'b0);
    checks++;
    if ({out_valid, uop, sel_p0, sel_p1, sel_in, num_to_rhs} !== {1'b1, 5'd1, 4'd2, 4'd1, 4'd0, 1'b0}) begin
      failures++;
      $display("FAIL add_reg got=%h want valid=1 uop=1 p0=2 p1=1 in=0 rhs=0", obs);
    end
  endtask
  task automatic test_branches();
    cyc(1'b1, 16'hD0FE, 1'b1, 1'b0);
    checks++;
    if ({out_valid, branch_cond, num, uop} !== {1'b1, 4'h0, 32'hFFFFFFFE, 5'd0}) begin
      failures++;
      $display("FAIL bcond got cond=%h num=%h uop=%0d want cond=0 num=fffffffe uop=0", branch_cond, num, uop);
    end
    cyc(1'b1, 16'hE7FF, 1'b1, 1'b0);
    checks++;
    if ({out_valid, branch_cond, num} !== {1'b1, 4'hE, 32'hFFFFFFFF}) begin
      failures++;
      $display("FAIL b_always got cond=%h num=%h want cond=e num=ffffffff", branch_cond, num);
    end
  endtask
  task automatic test_bl();
    cyc(1'b1, 16'hF000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bl_prefix_beat got valid=%b want 0", out_valid);
    end
    cyc(1'b1, 16'hF802, 1'b1, 1'b0);
    checks++;
    if ({out_valid, is_bl, sel_in, branch_cond, num, undef} !== {1'b1, 1'b1, 4'd14, 4'hE, 32'd2, 1'b0}) begin
      failures++;
      $display("FAIL bl_pair got=%h want valid=1 bl=1 in=14 cond=e num=2", obs);
    end
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bl_single_beat got valid=%b want 0", out_valid);
    end
    cyc(1'b1, 16'hF000, 1'b1, 1'b0);
    cyc(1'b1, 16'h2255, 1'b1, 1'b0);
    checks++;
    if ({out_valid, undef, is_bl, uop} !== {1'b1, 1'b1, 1'b0, 5'd0}) begin
      failures++;
      $display("FAIL bl_bad_suffix got=%h want undef beat", obs);
    end
    cyc(1'b1, 16'h2255, 1'b1, 1'b0);
    checks++;
    if ({out_valid, undef, uop, num, sel_in} !== {1'b1, 1'b0, 5'd8, 32'h55, 4'd2}) begin
      failures++;
      $display("FAIL mov_after_bl got=%h want mov r2 0x55", obs);
    end
  endtask
  task automatic test_stall();
    cyc(1'b1, 16'h2255, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'h3105, 1'b0, 1'b0);
      checks++;
      if ({in_ready, out_valid, uop, num, sel_in} !== {1'b0, 1'b1, 5'd8, 32'h55, 4'd2}) begin
        failures++;
        $display("FAIL stall%0d got=%h want ready=0 held mov beat", i, obs);
      end
    end
    cyc(1'b1, 16'h3105, 1'b1, 1'b0);
    checks++;
    if ({out_valid, uop, num, sel_p1, sel_in, num_to_rhs} !== {1'b1, 5'd1, 32'd5, 4'd1, 4'd1, 1'b1}) begin
      failures++;
      $display("FAIL stall_release got=%h want add r1 #5", obs);
    end
  endtask
  task automatic test_flush();
    cyc(1'b1, 16'hF000, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    cyc(1'b1, 16'hF802, 1'b1, 1'b0);
    checks++;
    if ({out_valid, undef, is_bl} !== {1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL flush_prefix got valid=%b undef=%b bl=%b want 1 1 0", out_valid, undef, is_bl);
    end
    cyc(1'b1, 16'h2255, 1'b1, 1'b0);
    cyc(1'b1, 16'h2211, 1'b1, 1'b1);
    checks++;
    if ({out_valid, num} !== {1'b0, 32'h55}) begin
      failures++;
      $display("FAIL flush_drop got valid=%b num=%h want 0 55", out_valid, num);
    end
  endtask
  task automatic test_orr_undef();
    cyc(1'b1, 16'h4308, 1'b1, 1'b0);
    checks++;
    if ({out_valid, uop, sel_p0, sel_in, sel_p1, undef} !== {1'b1, 5'd7, 4'd0, 4'd0, 4'd1, 1'b0}) begin
      failures++;
      $display("FAIL orr got=%h want uop=7 p0=0 in=0 p1=1", obs);
    end
    cyc(1'b1, 16'hBF00, 1'b1, 1'b0);
    checks++;
    if ({out_valid, undef, branch_cond} !== {1'b1, 1'b1, 4'hF}) begin
      failures++;
      $display("FAIL undef_bf00 got undef=%b cond=%h want 1 f", undef, branch_cond);
    end
    cyc(1'b1, 16'hF802, 1'b1, 1'b0);
    checks++;
    if ({out_valid, undef, is_bl} !== {1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL lone_suffix got undef=%b bl=%b want 1 0", undef, is_bl);
    end
  endtask
  task automatic test_reset_prefix();
    cyc(1'b1, 16'h2255, 1'b1, 1'b0);
    cyc(1'b1, 16'hF000, 1'b1, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({out_valid, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, branch_cond, is_bl, undef} !==
        {1'b0, 5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 4'hF, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got=%h want reset values", obs);
    end
    @(negedge clk) reset = 1'b1;
    cyc(1'b1, 16'hF802, 1'b1, 1'b0);
    checks++;
    if ({out_valid, undef, is_bl} !== {1'b1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL suffix_after_reset got undef=%b bl=%b want 1 0", undef, is_bl);
    end
  endtask
  task automatic test_back_to_back();
    logic [15:0] h;
    for (int n = 0; n < 100; n++) begin
      h = 16'($urandom);
      cyc(1'b1, h, 1'b1, 1'b0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL b2b n=%0d instr=%h got=%h exp=%h", n, h, obs, exp_vec());
      end
    end
  endtask
  task automatic test_random();
    int r;
    logic [15:0] h;
    for (int n = 0; n < 800; n++) begin
      r = int'($urandom_range(0, 9));
      h = 16'($urandom);
      if (r < 2) h = {5'b11110, h[10:0]};
      else if (r < 4) h = {5'b11111, h[10:0]};
      cyc($urandom_range(0, 3) != 0, h, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL rand n=%0d instr=%h got=%h exp=%h", n, h, obs, exp_vec());
      end
    end
  endtask
  initial begin
    test_reset();
    test_add_reg();
    test_branches();
    test_bl();
    test_stall();
    test_flush();
    test_orr_undef();
    test_reset_prefix();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
